instruction_loader: RTL and testbench

Byte-stream instruction loader for the MIPS debug path: collects bytes delivered by the UART receiver, packs them MSB-first into 32-bit instruction words, and writes them sequentially into instruction memory starting at address 0. It is the producer side of the instruction memory that the fetch and decode stages later consume. Loading ends when the HALT word has been written, or with an error if memory fills first. It reports completion and word count to the debug unit.

---
 rtl/instruction_loader.sv | 166 ++++++++++++++++
 tb/tb_instruction_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Collects UART bytes, packs them MSB-first into instruction
//               words and writes them sequentially into instruction memory
//               from address 0. A load ends in DONE once the HALT word has
//               been written, or in ERROR when the last address is written
//               with a word other than HALT.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clock        in   system clock, rising edge
//   i_reset        in   synchronous active-high reset
//   i_start_load   in   arms a new load from IDLE, DONE or ERROR
//   i_rx_data      in   received byte (NB_DATA)
//   i_rx_valid     in   one-cycle strobe per received byte
//   o_imem_wr_en   out  one-cycle write strobe to instruction memory
//   o_imem_addr    out  word address of the write (NB_ADDR)
//   o_imem_data    out  packed instruction word (NB_INSTRUCTION)
//   o_busy         out  load in progress
//   o_load_done    out  HALT word written
//   o_load_error   out  memory filled without HALT
//   o_instr_count  out  words written in current/last load (NB_ADDR+1)
// ============================================================================
module instruction_loader #(
  parameter int NB_DATA        = 8,
  parameter int NB_INSTRUCTION = 32,
  parameter int NB_ADDR        = 8,
  parameter logic [NB_INSTRUCTION-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start_load,
  input  logic [NB_DATA-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  output logic                      o_imem_wr_en,
  output logic [NB_ADDR-1:0]        o_imem_addr,
  output logic [NB_INSTRUCTION-1:0] o_imem_data,
  output logic                      o_busy,
  output logic                      o_load_done,
  output logic                      o_load_error,
  output logic [NB_ADDR:0]          o_instr_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  logic [1:0]                state;
  logic [1:0]                next_state;
  logic [1:0]                byte_cnt;
  logic [NB_INSTRUCTION-1:0] word_sr;
  logic                      wr_en;
  logic [NB_ADDR-1:0]        addr;
  logic [NB_INSTRUCTION-1:0] wr_data;
  logic [NB_ADDR:0]          count;
  logic                      busy;
  logic                      load_done;
  logic                      load_error;

  logic                      busy_d;
  logic                      done_d;
  logic                      error_d;

  logic                      accept_byte;
  logic                      word_complete;
  logic                      start_accept;
  logic                      write_is_halt;
  logic                      write_at_end;
  logic [NB_INSTRUCTION-1:0] packed_word;

  assign accept_byte   = (state == ST_RECEIVE) && i_rx_valid;
  assign word_complete = accept_byte && (byte_cnt == 2'd3);
  assign start_accept  = i_start_load && (state != ST_RECEIVE);
  assign packed_word   = {word_sr[NB_INSTRUCTION-NB_DATA-1:0], i_rx_data};

  // Termination is decided in the write cycle itself, from the registered
  // word and address, so the state change lands on the edge the strobe drops.
  assign write_is_halt = wr_en && (wr_data == HALT_WORD);
  assign write_at_end  = wr_en && (addr == LAST_ADDR);

  // State register, together with the registered status flags
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= busy_d;
      load_done  <= done_d;
      load_error <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start_load) next_state = ST_RECEIVE;
      end
      ST_RECEIVE: begin
        // HALT wins over a full memory
        if (write_is_halt)     next_state = ST_DONE;
        else if (write_at_end) next_state = ST_ERROR;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output logic: flags follow the state being entered so they are
  // registered alongside it
  always_comb begin
    busy_d  = (next_state == ST_RECEIVE);
    done_d  = (next_state == ST_DONE);
    error_d = (next_state == ST_ERROR);
  end

  // Datapath: byte packing, write strobe, address and word count
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      byte_cnt <= 2'd0;
      word_sr  <= '0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      addr     <= '0;
      count    <= '0;
    end else begin
      wr_en <= word_complete;
      if (word_complete) wr_data <= packed_word;

      if (start_accept) begin
        // A partial word from an earlier load is dropped here
        byte_cnt <= 2'd0;
        word_sr  <= '0;
        addr     <= '0;
        count    <= '0;
      end else begin
        if (accept_byte) begin
          word_sr  <= packed_word;
          byte_cnt <= byte_cnt + 2'd1;
        end
        if (wr_en) begin
          count <= count + (NB_ADDR+1)'(1);
          // The last address is held rather than wrapping to 0
          if (addr != LAST_ADDR) addr <= addr + NB_ADDR'(1);
        end
      end
    end
  end

  assign o_imem_wr_en  = wr_en;
  assign o_imem_addr   = addr;
  assign o_imem_data   = wr_data;
  assign o_busy        = busy;
  assign o_load_done   = load_done;
  assign o_load_error  = load_error;
  assign o_instr_count = count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Bench for instruction_loader. Directed load scenarios plus a
//               randomized byte/start/reset stream, all checked each cycle
//               against a word-level reference model of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

  localparam int          NB_ADDR_TB = 4;
  localparam int          DEPTH      = 1 << NB_ADDR_TB;
  localparam logic [31:0] HALT       = 32'hFFFF_FFFF;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start_load = 1'b0;
  logic [7:0]            rx_data = 8'h00;
  logic                  rx_valid = 1'b0;
  logic                  imem_wr_en;
  logic [NB_ADDR_TB-1:0] imem_addr;
  logic [31:0]           imem_data;
  logic                  busy;
  logic                  load_done;
  logic                  load_error;
  logic [NB_ADDR_TB:0]   instr_count;

  always #5 clk = ~clk;

  instruction_loader #(
    .NB_DATA(8),
    .NB_INSTRUCTION(32),
    .NB_ADDR(NB_ADDR_TB),
    .HALT_WORD(HALT)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_start_load(start_load),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_imem_wr_en(imem_wr_en),
    .o_imem_addr(imem_addr),
    .o_imem_data(imem_data),
    .o_busy(busy),
    .o_load_done(load_done),
    .o_load_error(load_error),
    .o_instr_count(instr_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes accumulate into a queue; every fourth byte forms
  // a word that must appear on the memory port in the following cycle.
  // Count and termination take effect one edge after the word is formed.
  bit          m_ok = 0;
  bit          m_loading, m_done, m_err;
  bit          m_wpend, m_halt_pend, m_full_pend, m_was_reset;
  int          m_addr, m_count;
  logic [7:0]  m_part[$];
  bit          exp_wr;
  int          exp_addr;
  logic [31:0] exp_data;

  task automatic model_step(input bit r, input bit s, input bit v, input logic [7:0] b);
    logic [31:0] w;
    exp_wr      = 0;
    m_was_reset = r;
    if (r) begin
      m_ok = 1; m_loading = 0; m_done = 0; m_err = 0;
      m_wpend = 0; m_halt_pend = 0; m_full_pend = 0;
      m_addr = 0; m_count = 0; m_part.delete();
      return;
    end
    if (!m_ok) return;
    if (m_wpend) begin
      m_wpend = 0;
      m_count++;
      if (m_halt_pend || m_full_pend) begin
        m_loading = 0;
        m_done = m_halt_pend;
        m_err  = m_full_pend;
        m_halt_pend = 0; m_full_pend = 0;
        m_part.delete();
        return;
      end
    end
    if (!m_loading) begin
      if (s) begin
        m_loading = 1; m_done = 0; m_err = 0;
        m_addr = 0; m_count = 0; m_part.delete();
      end
      return;
    end
    if (v) begin
      m_part.push_back(b);
      if (m_part.size() == 4) begin
        w = {m_part[0], m_part[1], m_part[2], m_part[3]};
        m_part.delete();
        exp_wr = 1; exp_addr = m_addr; exp_data = w; m_wpend = 1;
        if (w == HALT)                m_halt_pend = 1;
        else if (m_addr == DEPTH - 1) m_full_pend = 1;
        else                          m_addr++;
      end
    end
  endtask

  task automatic check_outputs();
    if (!m_ok) return;
    chk("wr_en", 64'(imem_wr_en), 64'(exp_wr));
    if (exp_wr) begin
      chk("wr_addr", 64'(imem_addr), 64'(exp_addr));
      chk("wr_data", 64'(imem_data), 64'(exp_data));
    end
    chk("busy",  64'(busy),        64'(m_loading));
    chk("done",  64'(load_done),   64'(m_done));
    chk("error", 64'(load_error),  64'(m_err));
    chk("count", 64'(instr_count), 64'(m_count));
    if (m_was_reset) begin
      chk("rst_addr", 64'(imem_addr), 64'd0);
      chk("rst_data", 64'(imem_data), 64'd0);
    end
  endtask

  // One clock cycle: check what the previous edge produced, then present
  // new inputs for the next edge and advance the model.
  task automatic drive(input bit r, input bit s, input bit v, input logic [7:0] b);
    @(negedge clk);
    check_outputs();
    rst = r; start_load = s; rx_valid = v; rx_data = b;
    model_step(r, s, v, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 8'($urandom));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) drive(0, 0, 1, w[i*8 +: 8]);
  endtask

  initial begin
    drive(1, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_count", 64'(instr_count), 64'd0);

    // Basic load: one word plus HALT, with gaps between bytes
    drive(0, 1, 0, 8'h00);
    drive(0, 0, 1, 8'h20); idle(1);
    drive(0, 0, 1, 8'h08); idle(2);
    drive(0, 0, 1, 8'h00);
    drive(0, 0, 1, 8'h05);
    idle(1);
    send_word(HALT);
    idle(3);
    chk("t1_done", 64'(load_done), 64'd1);
    chk("t1_count", 64'(instr_count), 64'd2);
    chk("t1_busy", 64'(busy), 64'd0);

    // Bytes in DONE without a start are ignored, then a fresh load
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    idle(2);
    chk("done_hold_count", 64'(instr_count), 64'd2);
    drive(0, 1, 0, 8'h00);
    send_word(32'hA0A1_A2A3);
    send_word(32'hB0B1_B2B3);
    send_word(32'hC0C1_C2C3);
    send_word(HALT);
    idle(3);
    chk("b2b_count", 64'(instr_count), 64'd4);

    // Start pulse mid-word is ignored
    drive(0, 1, 0, 8'h00);
    drive(0, 0, 1, 8'h11);
    drive(0, 1, 0, 8'h00);
    drive(0, 0, 1, 8'h22);
    drive(0, 0, 1, 8'h33);
    drive(0, 0, 1, 8'h44);
    send_word(HALT);
    idle(2);
    chk("mid_start_count", 64'(instr_count), 64'd2);

    // Reset with a partial word, then a HALT-only load
    drive(0, 1, 0, 8'h00);
    drive(0, 0, 1, 8'h55);
    drive(0, 0, 1, 8'h66);
    drive(1, 0, 0, 8'h00);
    idle(3);
    drive(0, 1, 0, 8'h00);
    send_word(HALT);
    idle(2);
    chk("halt_only_count", 64'(instr_count), 64'd1);

    // Fill memory without HALT; trailing bytes must not write
    drive(0, 1, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) send_word(32'h0000_0100 + i);
    send_word(32'h0102_0304);
    send_word(HALT);
    idle(2);
    chk("full_error", 64'(load_error), 64'd1);
    chk("full_count", 64'(instr_count), 64'(DEPTH));

    // HALT at the last address ends in DONE
    drive(0, 1, 0, 8'h00);
    for (int i = 0; i < DEPTH - 1; i++) send_word(32'h0000_0200 + i);
    send_word(HALT);
    idle(2);
    chk("halt_last_done", 64'(load_done), 64'd1);
    chk("halt_last_error", 64'(load_error), 64'd0);

    // Randomized stream of resets, starts and bytes biased toward 0xFF
    for (int i = 0; i < 4000; i++) begin
      bit          r, s, v;
      logic [7:0]  b;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 2) != 0);
      b = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      drive(r, s, v, b);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
